hazard_unit: RTL and testbench



---
 rtl/hazard_unit_if.sv | 48 ++++
 rtl/hazard_unit.sv | 169 ++++++++++++++++
 tb/tb_hazard_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// Control bundle between the MIPS datapath and its hazard unit.
// Counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_unit_if;
  // No valid/ready pairs here: ihit and dhit are single-cycle completion
  // strobes from the caches. Everything else is level-valid for the current cycle.
  logic       ihit;
  logic       dhit;
  logic       m_dREN;
  logic       m_dWEN;
  logic       e_dREN;
  logic [4:0] e_rt;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic       d_rt_used;
  logic       e_redirect;
  logic       d_halt;
  logic       w_halt;
  logic [1:0] fd_state;
  logic [1:0] de_state;
  logic [1:0] em_state;
  logic [1:0] mw_state;
  logic       pc_en;
  logic       halt;
  logic [1:0] dbg_state;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic [31:0] lu_cnt;
`endif

  modport hu (
    input  ihit, dhit, m_dREN, m_dWEN, e_dREN, e_rt, d_rs, d_rt,
           d_rt_used, e_redirect, d_halt, w_halt,
    output fd_state, de_state, em_state, mw_state, pc_en, halt, dbg_state
`ifdef HAZARD_PERF_EN
    , output stall_cnt, flush_cnt, lu_cnt
`endif
  );

  modport dp (
    output ihit, dhit, m_dREN, m_dWEN, e_dREN, e_rt, d_rs, d_rt,
           d_rt_used, e_redirect, d_halt, w_halt,
    input  fd_state, de_state, em_state, mw_state, pc_en, halt, dbg_state
`ifdef HAZARD_PERF_EN
    , input stall_cnt, flush_cnt, lu_cnt
`endif
  );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage pipeline controller: load-use, cache-miss, redirect and halt drain.
// Define HAZARD_PERF_EN to add stall/flush/load-use event counters.
package cpu_types_pkg;
  typedef logic [4:0] regbits_t;
  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'b00,
    PIPE_STALL  = 2'b01,
    PIPE_NOP    = 2'b10
  } pipe_state_t;
endpackage

module hazard_unit
  import cpu_types_pkg::*;
(
  input  logic      CLK,
  input  logic      nRST,
  hazard_unit_if.hu hif
);

  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_DRAIN  = 2'b01,
    S_HALTED = 2'b10
  } hu_state_e;

  typedef enum logic [2:0] {
    R_MEMSTALL = 3'd0,
    R_REDIRECT = 3'd1,
    R_LOADUSE  = 3'd2,
    R_IMISS    = 3'd3,
    R_CLEAR    = 3'd4
  } rule_e;

  hu_state_e   state_q, state_d;
  rule_e       rule;
  regbits_t    e_rt, d_rs, d_rt;
  logic        memstall;
  logic        loaduse;
  pipe_state_t fd_st, de_st, em_st, mw_st;
  logic        pc_en;

  assign e_rt = hif.e_rt;
  assign d_rs = hif.d_rs;
  assign d_rt = hif.d_rt;

  assign memstall = (hif.m_dREN | hif.m_dWEN) & ~hif.dhit;
  // Register zero is hardwired, so a load targeting it never creates a hazard.
  assign loaduse  = hif.e_dREN & (e_rt != '0) &
                    ((e_rt == d_rs) | (hif.d_rt_used & (e_rt == d_rt)));

  always_comb begin
    rule = R_CLEAR;
    if (memstall)            rule = R_MEMSTALL;
    else if (hif.e_redirect) rule = R_REDIRECT;
    else if (loaduse)        rule = R_LOADUSE;
    else if (!hif.ihit)      rule = R_IMISS;
  end

  always_comb begin
    fd_st = PIPE_ENABLE;
    de_st = PIPE_ENABLE;
    em_st = PIPE_ENABLE;
    mw_st = PIPE_ENABLE;
    pc_en = 1'b1;
    if (!nRST) begin
      fd_st = PIPE_NOP;
      de_st = PIPE_NOP;
      em_st = PIPE_NOP;
      mw_st = PIPE_NOP;
      pc_en = 1'b0;
    end else if (state_q == S_HALTED) begin
      fd_st = PIPE_STALL;
      de_st = PIPE_STALL;
      em_st = PIPE_STALL;
      mw_st = PIPE_STALL;
      pc_en = 1'b0;
    end else begin
      case (rule)
        R_MEMSTALL: begin
          fd_st = PIPE_STALL;
          de_st = PIPE_STALL;
          em_st = PIPE_STALL;
          mw_st = PIPE_NOP;
          pc_en = 1'b0;
        end
        R_REDIRECT: begin
          fd_st = PIPE_NOP;
          de_st = PIPE_NOP;
        end
        R_LOADUSE: begin
          fd_st = PIPE_STALL;
          de_st = PIPE_NOP;
          pc_en = 1'b0;
        end
        default: begin
          // Instruction miss, or draining: stop fetching and feed bubbles.
          if (rule == R_IMISS || state_q == S_DRAIN) begin
            fd_st = PIPE_NOP;
            pc_en = 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (hif.w_halt && !memstall)
          state_d = S_HALTED;
        else if (hif.d_halt && rule == R_CLEAR)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (hif.w_halt && !memstall)
          state_d = S_HALTED;
      end
      default: state_d = S_HALTED;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  assign hif.fd_state  = fd_st;
  assign hif.de_state  = de_st;
  assign hif.em_state  = em_st;
  assign hif.mw_state  = mw_st;
  assign hif.pc_en     = pc_en;
  assign hif.halt      = nRST & (state_q == S_HALTED);
  assign hif.dbg_state = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] lu_cnt_q, lu_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    lu_cnt_d    = lu_cnt_q;
    if (state_q != S_HALTED) begin
      if (state_q == S_RUN && !pc_en) stall_cnt_d = stall_cnt_q + 32'd1;
      if (rule == R_REDIRECT)         flush_cnt_d = flush_cnt_q + 32'd1;
      if (rule == R_LOADUSE)          lu_cnt_d    = lu_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
    end
  end

  assign hif.stall_cnt = nRST ? stall_cnt_q : '0;
  assign hif.flush_cnt = nRST ? flush_cnt_q : '0;
  assign hif.lu_cnt    = nRST ? lu_cnt_q    : '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit with a queue-based scoreboard.
// Counter checks are compiled in when HAZARD_PERF_EN is defined.
module tb_hazard_unit;

  localparam logic [1:0] EN = 2'b00;
  localparam logic [1:0] ST = 2'b01;
  localparam logic [1:0] NP = 2'b10;

  logic clk;
  logic nrst;
  int   total = 0;
  int   bad   = 0;

  logic [9:0] exp_q[$];
  string      name_q[$];

  hazard_unit_if hif();

  hazard_unit u_dut (
    .CLK  (clk),
    .nRST (nrst),
    .hif  (hif.hu)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [9:0] v(input logic [1:0] fd, input logic [1:0] de,
                                   input logic [1:0] em, input logic [1:0] mw,
                                   input logic pc, input logic h);
    return {fd, de, em, mw, pc, h};
  endfunction

  // Driver tasks
  task automatic set_idle();
    hif.ihit       = 1'b1;
    hif.dhit       = 1'b1;
    hif.m_dREN     = 1'b0;
    hif.m_dWEN     = 1'b0;
    hif.e_dREN     = 1'b0;
    hif.e_rt       = 5'd0;
    hif.d_rs       = 5'd0;
    hif.d_rt       = 5'd0;
    hif.d_rt_used  = 1'b0;
    hif.e_redirect = 1'b0;
    hif.d_halt     = 1'b0;
    hif.w_halt     = 1'b0;
  endtask

  task automatic set_loaduse();
    hif.e_dREN = 1'b1;
    hif.e_rt   = 5'd5;
    hif.d_rs   = 5'd5;
  endtask

  task automatic apply(input string nm, input logic [9:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Scoreboard monitor: compares on the falling edge, mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [9:0] e;
      logic [9:0] a;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {hif.fd_state, hif.de_state, hif.em_state, hif.mw_state, hif.pc_en, hif.halt};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got fd/de/em/mw/pc/halt=%b want %b", nm, a, e);
      end
    end
  end

  initial begin
    nrst = 1'b0;
    set_idle();
    @(posedge clk);
    #1;

    apply("reset", v(NP, NP, NP, NP, 1'b0, 1'b0));
    nrst = 1'b1;
    apply("idle", v(EN, EN, EN, EN, 1'b1, 1'b0));

    // Load-use: one bubble then clear
    set_loaduse();
    apply("lu_rs", v(ST, NP, EN, EN, 1'b0, 1'b0));
    set_idle();
    apply("lu_after", v(EN, EN, EN, EN, 1'b1, 1'b0));
    hif.e_dREN = 1'b1;
    apply("lu_r0", v(EN, EN, EN, EN, 1'b1, 1'b0));
    hif.e_rt = 5'd7; hif.d_rt = 5'd7; hif.d_rs = 5'd3;
    apply("lu_rt_unused", v(EN, EN, EN, EN, 1'b1, 1'b0));
    hif.d_rt_used = 1'b1;
    apply("lu_rt_used", v(ST, NP, EN, EN, 1'b0, 1'b0));

    // Memory stall dominates a pending redirect
    set_idle();
    hif.m_dREN = 1'b1; hif.dhit = 1'b0; hif.e_redirect = 1'b1;
    for (int i = 0; i < 3; i++) apply("memstall", v(ST, ST, ST, NP, 1'b0, 1'b0));
    hif.dhit = 1'b1;
    apply("redirect_after_stall", v(NP, NP, EN, EN, 1'b1, 1'b0));
    set_idle();
    hif.m_dWEN = 1'b1; hif.dhit = 1'b0;
    apply("memstall_wen", v(ST, ST, ST, NP, 1'b0, 1'b0));

    // Instruction miss, then load-use winning over the miss
    set_idle();
    hif.ihit = 1'b0;
    apply("imiss", v(NP, EN, EN, EN, 1'b0, 1'b0));
    set_loaduse();
    apply("lu_over_imiss", v(ST, NP, EN, EN, 1'b0, 1'b0));

    // Halt killed by redirect stays in RUN
    set_idle();
    hif.d_halt = 1'b1; hif.e_redirect = 1'b1;
    apply("halt_killed", v(NP, NP, EN, EN, 1'b1, 1'b0));
    set_idle();
    apply("still_run", v(EN, EN, EN, EN, 1'b1, 1'b0));

    // Halt advances: drain, then halted
    hif.d_halt = 1'b1;
    apply("halt_adv", v(EN, EN, EN, EN, 1'b1, 1'b0));
    set_idle();
    apply("drain", v(NP, EN, EN, EN, 1'b0, 1'b0));
    hif.w_halt = 1'b1; hif.m_dREN = 1'b1; hif.dhit = 1'b0;
    apply("drain_wh_memstall", v(ST, ST, ST, NP, 1'b0, 1'b0));
    hif.dhit = 1'b1;
    apply("drain_wh", v(NP, EN, EN, EN, 1'b0, 1'b0));
    set_idle();
    apply("halted", v(ST, ST, ST, ST, 1'b0, 1'b1));
    set_loaduse(); hif.e_redirect = 1'b1;
    apply("halted_sticky", v(ST, ST, ST, ST, 1'b0, 1'b1));

    // Reset out of HALTED
    set_idle();
    nrst = 1'b0;
    apply("reset_halted", v(NP, NP, NP, NP, 1'b0, 1'b0));
    nrst = 1'b1;
    apply("run_after_reset", v(EN, EN, EN, EN, 1'b1, 1'b0));

    // Reset mid-drain
    hif.d_halt = 1'b1;
    apply("halt_adv2", v(EN, EN, EN, EN, 1'b1, 1'b0));
    set_idle();
    apply("drain2", v(NP, EN, EN, EN, 1'b0, 1'b0));
    nrst = 1'b0;
    apply("reset_drain", v(NP, NP, NP, NP, 1'b0, 1'b0));
    nrst = 1'b1;
    apply("run_after_drain_reset", v(EN, EN, EN, EN, 1'b1, 1'b0));

`ifdef HAZARD_PERF_EN
    nrst = 1'b0;
    #1;
    check_val("stall_cnt_rst", hif.stall_cnt, 32'd0);
    check_val("lu_cnt_rst", hif.lu_cnt, 32'd0);
    apply("perf_reset", v(NP, NP, NP, NP, 1'b0, 1'b0));
    nrst = 1'b1;
    apply("perf_idle", v(EN, EN, EN, EN, 1'b1, 1'b0));
    set_loaduse();
    apply("perf_lu1", v(ST, NP, EN, EN, 1'b0, 1'b0));
    set_idle();
    apply("perf_idle2", v(EN, EN, EN, EN, 1'b1, 1'b0));
    set_loaduse();
    apply("perf_lu2", v(ST, NP, EN, EN, 1'b0, 1'b0));
    set_idle();
    hif.e_redirect = 1'b1;
    apply("perf_redirect", v(NP, NP, EN, EN, 1'b1, 1'b0));
    set_idle();
    apply("perf_idle3", v(EN, EN, EN, EN, 1'b1, 1'b0));
    check_val("lu_cnt", hif.lu_cnt, 32'd2);
    check_val("flush_cnt", hif.flush_cnt, 32'd1);
    check_val("stall_cnt", hif.stall_cnt, 32'd2);
`endif

    // Final report
    @(negedge clk);
    #1;
    check_val("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
